cla_nibble_seq: RTL and testbench



---
 rtl/cla_nibble_seq.sv | 100 ++++++++++
 tb/tb_cla_nibble_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_seq.sv
// Multi-cycle WIDTH-bit adder that time-shares one external 4-bit carry-lookahead
// slice, one nibble per clock, least-significant nibble first.
module cla_nibble_seq #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic             last_nibble;

  assign last_nibble = (idx == LAST_IDX);
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  // The slice is only fed while a pass is in progress; quiet zeros otherwise.
  always_comb begin
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[4*idx +: 4];
      slice_b   = b_reg[4*idx +: 4];
      slice_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_sum;
          carry_reg       <= slice_cout;
          if (last_nibble) begin
            // Overflow: carry into the MSB (a^b^s) differs from carry out.
            idx   <= '0;
            cout  <= slice_cout;
            ovf   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ slice_sum[3] ^ slice_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Self-checking bench for cla_nibble_seq: directed corner cases, reset abort,
// backpressure and a random back-to-back run against an arithmetic model.
module tb_cla_nibble_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_done_cyc = -1;

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  // External combinational 4-bit adder slice.
  assign {slice_cout, slice_sum} = slice_a + slice_b + {3'b000, slice_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slice_idle(input string tag);
    chk({tag, "_slice_a"}, 64'(slice_a), 64'd0);
    chk({tag, "_slice_b"}, 64'(slice_b), 64'd0);
    chk({tag, "_slice_cin"}, 64'(slice_cin), 64'd0);
  endtask

  // Starts in IDLE, accepts (x,y,c), walks the nibbles and stops in DONE with results checked.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit hold_valid, input bit check_rate);
    logic [63:0] full, lo_a, lo_b, mask, cin_k;
    logic        exp_ovf;
    full    = 64'(x) + 64'(y) + 64'(c);
    exp_ovf = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk_slice_idle("idle");
    a = x; b = y; cin = c; in_valid = 1'b1;
    step();
    in_valid = hold_valid;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < N; k++) begin
      mask  = (64'd1 << (4 * k)) - 64'd1;
      lo_a  = 64'(x) & mask;
      lo_b  = 64'(y) & mask;
      cin_k = (lo_a + lo_b + 64'(c)) >> (4 * k);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      chk("run_out_valid", 64'(out_valid), 64'd0);
      chk("run_slice_a", 64'(slice_a), (64'(x) >> (4 * k)) & 64'hF);
      chk("run_slice_b", 64'(slice_b), (64'(y) >> (4 * k)) & 64'hF);
      chk("run_slice_cin", 64'(slice_cin), cin_k);
      step();
    end
    chk("done_out_valid", 64'(out_valid), 64'd1);
    chk("done_sum", 64'(sum), full & ((64'd1 << W) - 64'd1));
    chk("done_cout", 64'(cout), (full >> W) & 64'd1);
    chk("done_ovf", 64'(ovf), 64'(exp_ovf));
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    chk_slice_idle("done");
    if (check_rate && last_done_cyc >= 0)
      chk("b2b_period", 64'(cyc - last_done_cyc), 64'(N + 2));
    last_done_cyc = cyc;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf;

    // Reset state
    #2;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk_slice_idle("rst");
    step();
    rst = 1'b0;
    step();

    // Directed cases
    out_ready = 1'b1;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    release_result();
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    release_result();
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    release_result();
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    release_result();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    release_result();

    // Reset in the middle of a pass
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    #1;
    rst = 1'b0;
    step();
    run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
    release_result();

    // Backpressure in DONE
    out_ready = 1'b0;
    run_op(16'h9A5C, 16'hC3E7, 1'b1, 1'b1, 1'b0);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      step();
      chk("bp_sum", 64'(sum), 64'(held_sum));
      chk("bp_cout", 64'(cout), 64'(held_cout));
      chk("bp_ovf", 64'(ovf), 64'(held_ovf));
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    release_result();
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b1, 1'b0);
    release_result();

    // Back-to-back random traffic
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_done_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b1);
      step();
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      chk_slice_idle("b2b");
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
